// File: rtl/vaddsub_chunk_sequencer.sv
// vaddsub_chunk_sequencer
//   Feeds one VLEN-wide vector add/sub op through a 32-bit SIMD adder, one
//   32-bit chunk per cycle. Each returned sum chunk is merged byte by byte
//   with the old destination: tail elements (index >= vl) keep vd_old. The
//   assembled vd is then presented on a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   in_valid/in_ready op request handshake; in_ready is high only in IDLE
//   in_sub            0 = vs2+vs1, 1 = vs2-vs1
//   in_sew            00 = 8b, 01 = 16b, 10 = 32b, 11 = illegal
//   in_vl             active element count (clamped to VLMAX)
//   in_vs1/in_vs2     operand B / operand A sources
//   in_vd_old         old destination, supplies tail elements
//   add_ctrl, add_sew_16_32, add_sew_32, add_a, add_b
//                     drive the external adder (all zero outside RUN)
//   add_sum           adder result, combinational in the same cycle
//   out_valid/out_ready result handshake
//   out_vd            assembled result
//   out_err           illegal SEW, qualified by out_valid
module vaddsub_chunk_sequencer #(
  parameter int VLEN = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sub,
  input  logic [1:0]                    in_sew,
  input  logic [$clog2(VLEN/8):0]       in_vl,
  input  logic [VLEN-1:0]               in_vs1,
  input  logic [VLEN-1:0]               in_vs2,
  input  logic [VLEN-1:0]               in_vd_old,
  output logic                          add_ctrl,
  output logic                          add_sew_16_32,
  output logic                          add_sew_32,
  output logic [31:0]                   add_a,
  output logic [31:0]                   add_b,
  input  logic [31:0]                   add_sum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VLEN-1:0]               out_vd,
  output logic                          out_err
);

  localparam int NCHUNK = VLEN / 32;
  localparam int VL_W   = $clog2(VLEN/8) + 1;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [VLEN-1:0]  res;

  logic             sub;
  logic [1:0]       sew;
  logic [VL_W-1:0]  vl_c;
  logic [VLEN-1:0]  vs1;
  logic [VLEN-1:0]  vs2;

  logic             accept;
  logic             run;
  logic [VL_W-1:0]  vlmax;
  logic [VL_W-1:0]  in_vl_c;
  logic [31:0]      chunk_a;
  logic [31:0]      chunk_b;
  logic [31:0]      chunk_old;
  logic [31:0]      chunk_res;
  logic [VL_W-1:0]  byte_idx;
  logic [VL_W-1:0]  elem_idx;

  assign accept = (state == S_IDLE) && in_valid;
  assign run    = (state == S_RUN);

  always_comb begin
    vlmax = VL_W'(VLEN / 32);
    case (in_sew)
      2'b00:   vlmax = VL_W'(VLEN / 8);
      2'b01:   vlmax = VL_W'(VLEN / 16);
      default: vlmax = VL_W'(VLEN / 32);
    endcase
    in_vl_c = (in_vl > vlmax) ? vlmax : in_vl;
  end

  // res is preloaded with vd_old on accept, so the chunk about to be
  // overwritten still holds the old destination bytes for the tail merge.
  always_comb begin
    chunk_a   = vs2[cnt*32 +: 32];
    chunk_b   = vs1[cnt*32 +: 32];
    chunk_old = res[cnt*32 +: 32];
    chunk_res = chunk_old;
    byte_idx  = '0;
    elem_idx  = '0;
    for (int j = 0; j < 4; j++) begin
      byte_idx = VL_W'({cnt, 2'(j)});
      elem_idx = byte_idx >> sew;
      chunk_res[j*8 +: 8] = (elem_idx < vl_c) ? add_sum[j*8 +: 8] : chunk_old[j*8 +: 8];
    end
  end

  assign in_ready      = (state == S_IDLE);
  assign out_valid     = (state == S_DONE);
  assign out_err       = out_valid & err;
  assign out_vd        = res;
  assign add_ctrl      = run & sub;
  assign add_sew_32    = run & (sew == 2'b10);
  assign add_sew_16_32 = run & ((sew == 2'b01) || (sew == 2'b10));
  assign add_a         = run ? chunk_a : 32'h0;
  assign add_b         = run ? chunk_b : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            err   <= (in_sew == 2'b11);
            res   <= in_vd_old;
            state <= (in_sew == 2'b11) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          res[cnt*32 +: 32] <= chunk_res;
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand registers carry no reset; they are only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      sub  <= in_sub;
      sew  <= in_sew;
      vl_c <= in_vl_c;
      vs1  <= in_vs1;
      vs2  <= in_vs2;
    end
  end

endmodule

// File: tb/tb_vaddsub_chunk_sequencer.sv
module tb_vaddsub_chunk_sequencer;
  localparam int VLEN   = 128;
  localparam int NCHUNK = VLEN / 32;
  localparam int VL_W   = $clog2(VLEN/8) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_sub;
  logic [1:0]      in_sew;
  logic [VL_W-1:0] in_vl;
  logic [VLEN-1:0] in_vs1, in_vs2, in_vd_old;
  logic            add_ctrl, add_sew_16_32, add_sew_32;
  logic [31:0]     add_a, add_b, add_sum;
  logic            out_valid, out_ready, out_err;
  logic [VLEN-1:0] out_vd;

  always #5 clk = ~clk;

  vaddsub_chunk_sequencer #(.VLEN(VLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub), .in_sew(in_sew),
    .in_vl(in_vl), .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd_old(in_vd_old),
    .add_ctrl(add_ctrl), .add_sew_16_32(add_sew_16_32), .add_sew_32(add_sew_32),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_vd(out_vd), .out_err(out_err)
  );

  // Behavioural SIMD adder: independent lanes, carries dropped at lane edges.
  always_comb begin
    add_sum = '0;
    case ({add_sew_32, add_sew_16_32})
      2'b11: add_sum = add_ctrl ? add_a - add_b : add_a + add_b;
      2'b01: for (int h = 0; h < 2; h++)
               add_sum[h*16 +: 16] = add_ctrl ? add_a[h*16 +: 16] - add_b[h*16 +: 16]
                                              : add_a[h*16 +: 16] + add_b[h*16 +: 16];
      default: for (int k = 0; k < 4; k++)
               add_sum[k*8 +: 8] = add_ctrl ? add_a[k*8 +: 8] - add_b[k*8 +: 8]
                                            : add_a[k*8 +: 8] + add_b[k*8 +: 8];
    endcase
  end

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;
  logic [VLEN-1:0] exp_vd;
  logic exp_err;

  task automatic chk(input string name, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Element-level reference: vd = vd_old with elements [0, min(vl,VLMAX)) replaced.
  function automatic logic [VLEN-1:0] model(input logic sub, input logic [1:0] sew, input int vl,
                                            input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2,
                                            input logic [VLEN-1:0] vdold);
    logic [VLEN-1:0] r;
    logic [31:0] a, b, s, mask;
    int w, n;
    r = vdold;
    if (sew == 2'b11) return r;
    w = 8 << sew;
    n = (vl > VLEN / w) ? VLEN / w : vl;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    for (int e = 0; e < n; e++) begin
      a = 32'(vs2 >> (e * w)) & mask;
      b = 32'(vs1 >> (e * w)) & mask;
      s = (sub ? a - b : a + b) & mask;
      r = (r & ~(VLEN'(mask) << (e * w))) | (VLEN'(s) << (e * w));
    end
    return r;
  endfunction

  // Compare process: every cycle a result is presented.
  always @(negedge clk) begin
    if (out_valid) begin
      if (!armed) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid got=1 exp=0");
      end else begin
        chk("out_vd", out_vd, exp_vd);
        chk("out_err", VLEN'(out_err), VLEN'(exp_err));
        chk("in_ready_busy", VLEN'(in_ready), '0);
      end
    end
  end

  task automatic run_op(input logic sub, input logic [1:0] sew, input int vl,
                        input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2,
                        input logic [VLEN-1:0] vdold, input int hold,
                        output logic [VLEN-1:0] mres);
    int lat;
    int guard;
    mres    = model(sub, sew, vl, vs1, vs2, vdold);
    exp_vd  = mres;
    exp_err = (sew == 2'b11);
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_idle", VLEN'(in_ready), VLEN'(1));
    in_valid = 1'b1; in_sub = sub; in_sew = sew; in_vl = VL_W'(vl);
    in_vs1 = vs1; in_vs2 = vs2; in_vd_old = vdold;
    armed = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sub = ~sub; in_sew = ~sew; in_vl = ~in_vl;
    in_vs1 = ~vs1; in_vs2 = ~vs2; in_vd_old = ~vdold;
    lat = 0;
    while (lat < 30) begin
      lat++;
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
    end
    chk("latency", VLEN'(lat), VLEN'((sew == 2'b11) ? 1 : NCHUNK + 1));
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("release_valid", VLEN'(out_valid), '0);
    chk("release_ready", VLEN'(in_ready), VLEN'(1));
    armed = 1'b0;
  endtask

  logic [VLEN-1:0] m;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_sew = 2'b00; in_vl = '0;
    in_vs1 = '0; in_vs2 = '0; in_vd_old = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", VLEN'(out_valid), '0);
    chk("rst_out_err", VLEN'(out_err), '0);
    chk("rst_out_vd", out_vd, '0);
    chk("rst_in_ready", VLEN'(in_ready), VLEN'(1));
    chk("rst_add_ab", VLEN'({add_a, add_b}), '0);
    chk("rst_add_ctl", VLEN'({add_ctrl, add_sew_16_32, add_sew_32}), '0);
    rst_n = 1'b1;

    // T1: 32-bit add
    run_op(1'b0, 2'b10, 4, {4{32'h3}}, {4{32'h5}}, {4{32'hCAFE_F00D}}, 0, m);
    chk("t1_model", m, {4{32'h0000_0008}});
    // T2: byte subtract with lane wrap
    run_op(1'b1, 2'b00, 16, {16{8'h01}}, '0, {16{8'h5A}}, 1, m);
    chk("t2_model", m, {16{8'hFF}});
    // T3: 16-bit add, tail undisturbed
    run_op(1'b0, 2'b01, 3, {8{16'h0001}}, {8{16'hFFFF}}, {16{8'hAA}}, 2, m);
    chk("t3_model", m, {{5{16'hAAAA}}, {3{16'h0000}}});
    // T4: illegal SEW, then a legal op right after
    run_op(1'b1, 2'b11, 4, {4{32'h1}}, {4{32'h2}}, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, m);
    chk("t4_model", m, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    run_op(1'b1, 2'b10, 2, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd40, 32'd30, 32'd20, 32'd10},
           {4{32'hDEAD_BEEF}}, 0, m);
    chk("t4b_model", m, {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h11, 32'h6});
    // T5: long hold in DONE, vl above VLMAX clamps
    run_op(1'b0, 2'b00, 31, {16{8'h22}}, {16{8'h10}}, {16{8'h99}}, 10, m);
    chk("t5_model", m, {16{8'h32}});
    // Boundaries: vl=0, 32-bit wrap with clamp, tail split inside a chunk
    run_op(1'b0, 2'b01, 0, {8{16'h1111}}, {8{16'h2222}}, {16{8'h3C}}, 0, m);
    chk("vl0_model", m, {16{8'h3C}});
    run_op(1'b0, 2'b10, 20, {4{32'h1}}, {4{32'hFFFF_FFFF}}, {4{32'h5555_5555}}, 0, m);
    chk("wrap32_model", m, '0);
    run_op(1'b0, 2'b01, 5, {8{16'h8000}}, {8{16'h8000}}, {16{8'h77}}, 0, m);
    chk("split_model", m, {{3{16'h7777}}, {5{16'h0000}}});

    // T6: reset during RUN at cnt=2 aborts the op
    @(negedge clk);
    in_valid = 1'b1; in_sub = 1'b0; in_sew = 2'b10; in_vl = VL_W'(4);
    in_vs1 = {4{32'h2}}; in_vs2 = {4{32'h1}}; in_vd_old = {4{32'hAAAA_0000}};
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t6_run_add_a", VLEN'(add_a), VLEN'(32'h1));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", VLEN'(in_ready), VLEN'(1));
    chk("t6_out_valid", VLEN'(out_valid), '0);
    chk("t6_out_vd", out_vd, '0);
    chk("t6_add_a", VLEN'(add_a), '0);
    repeat (8) @(negedge clk);
    run_op(1'b1, 2'b00, 10, {16{8'h05}}, {16{8'h03}}, {16{8'hEE}}, 1, m);
    chk("t6_model", m, {{6{8'hEE}}, {10{8'hFE}}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
